// File: rtl/fetch_align_queue_if.sv
// Fetch/decode handshake bundle for fetch_align_queue.
// master: the queue itself; slave: the surrounding I-cache, branch unit and decode.
interface fetch_align_queue_if;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        I_ren;
  logic [29:0] I_addr;
  logic        I_stall;
  logic [31:0] I_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_is16;

  modport master (
    input  flush, redirect_pc, I_stall, I_rdata, inst_ready,
    output I_ren, I_addr, inst_valid, inst_out, inst_pc, inst_is16
  );

  modport slave (
    output flush, redirect_pc, I_stall, I_rdata, inst_ready,
    input  I_ren, I_addr, inst_valid, inst_out, inst_pc, inst_is16
  );
endinterface

// File: rtl/fetch_align_queue.sv
// Instruction prefetch and realignment queue: buffers fetched words as
// halfwords and presents one aligned 16- or 32-bit instruction per cycle.
// Define RVC_ALIGN_EN for mixed 16/32-bit streams and halfword redirects;
// without it every instruction is 32-bit and redirects are word aligned.
module fetch_align_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_align_queue_if.master  bus
);
  localparam int unsigned    AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FILL_LIMIT = (AW+1)'(DEPTH - 2);
  localparam logic [AW-1:0]  PTR_ONE    = 1;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_head_pc;
  logic          r_drop_first;

  logic [AW-1:0] w_rd1;
  logic [15:0]   w_h0;
  logic [15:0]   w_h1;
  logic          w_is16;
  logic          w_valid;
  logic          w_ren;
  logic          w_accept;
  logic          w_pop;
  logic [AW:0]   w_push_n;
  logic [AW:0]   w_pop_n;
  logic          w_unused;

  assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

  // Head decode, request and handshake qualification.
  always_comb begin
    w_rd1 = r_rd + PTR_ONE;
    w_h0  = r_mem[r_rd];
    w_h1  = r_mem[w_rd1];
`ifdef RVC_ALIGN_EN
    w_is16 = (w_h0[1:0] != 2'b11);
`else
    w_is16 = 1'b0;
`endif
    w_valid  = w_is16 ? (r_count != '0) : (r_count >= (AW+1)'(2));
    // Request only when room for a full word exists before any pop this cycle.
    w_ren    = ~bus.flush & ~rst & (r_count <= FILL_LIMIT);
    w_accept = w_ren & ~bus.I_stall;
    w_pop    = w_valid & bus.inst_ready & ~bus.flush;
    w_push_n = '0;
    if (w_accept) w_push_n = r_drop_first ? (AW+1)'(1) : (AW+1)'(2);
    w_pop_n  = '0;
    if (w_pop) w_pop_n = w_is16 ? (AW+1)'(1) : (AW+1)'(2);
  end

  // Outputs to the I-cache and decode.
  always_comb begin
    bus.I_ren      = w_ren;
    bus.I_addr     = r_fetch_pc[31:2];
    bus.inst_valid = w_valid;
    bus.inst_pc    = r_head_pc;
    bus.inst_is16  = w_valid & w_is16;
    bus.inst_out   = '0;
    if (w_valid) bus.inst_out = w_is16 ? {16'h0000, w_h0} : {w_h1, w_h0};
  end

  // Halfword storage; a dropped low half writes only the upper halfword.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_drop_first) begin
        r_mem[r_wr] <= bus.I_rdata[31:16];
      end else begin
        r_mem[r_wr]         <= bus.I_rdata[15:0];
        r_mem[r_wr+PTR_ONE] <= bus.I_rdata[31:16];
      end
    end
  end

  // Pointers, occupancy, fetch/head PCs and redirect handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd         <= '0;
      r_wr         <= '0;
      r_count      <= '0;
      r_fetch_pc   <= RESET_PC;
      r_head_pc    <= RESET_PC;
      r_drop_first <= 1'b0;
    end else if (bus.flush) begin
      r_rd         <= '0;
      r_wr         <= '0;
      r_count      <= '0;
      r_fetch_pc   <= {bus.redirect_pc[31:2], 2'b00};
`ifdef RVC_ALIGN_EN
      r_head_pc    <= bus.redirect_pc;
      r_drop_first <= bus.redirect_pc[1];
`else
      r_head_pc    <= {bus.redirect_pc[31:2], 2'b00};
      r_drop_first <= 1'b0;
`endif
    end else begin
      r_count <= r_count + w_push_n - w_pop_n;
      if (w_accept) begin
        r_wr         <= r_wr + w_push_n[AW-1:0];
        r_fetch_pc   <= r_fetch_pc + 32'd4;
        r_drop_first <= 1'b0;
      end
      if (w_pop) begin
        r_rd      <= r_rd + w_pop_n[AW-1:0];
        r_head_pc <= r_head_pc + (w_is16 ? 32'd2 : 32'd4);
      end
    end
  end
endmodule
